// File: rtl/pwm_regs_pkg.sv
// Register map, ramp_ctrl bit positions and sequencer state encoding shared by
// the PWM register owner and the SPI peripheral.
package pwm_regs_pkg;

  localparam logic [6:0] ADDR_EN_OUT_LO     = 7'h00;
  localparam logic [6:0] ADDR_EN_OUT_HI     = 7'h01;
  localparam logic [6:0] ADDR_EN_PWM_LO     = 7'h02;
  localparam logic [6:0] ADDR_EN_PWM_HI     = 7'h03;
  localparam logic [6:0] ADDR_DUTY          = 7'h04;
  localparam logic [6:0] ADDR_RAMP_TARGET   = 7'h05;
  localparam logic [6:0] ADDR_RAMP_STEP     = 7'h06;
  localparam logic [6:0] ADDR_RAMP_PRESCALE = 7'h07;
  localparam logic [6:0] ADDR_RAMP_CTRL     = 7'h08;

  localparam int CTRL_START_BIT = 0;
  localparam int CTRL_LOOP_BIT  = 1;
  localparam int CTRL_STOP_BIT  = 2;

  typedef enum logic {
    SEQ_IDLE = 1'b0,
    SEQ_RAMP = 1'b1
  } seq_state_t;

endpackage

// File: rtl/ramp_tick_gen.sv
// Ramp prescaler: counts 0..prescale_i and flags the cycle the count equals
// prescale_i, giving one tick every prescale_i+1 cycles.
module ramp_tick_gen #(
  parameter int TICK_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic [TICK_W-1:0] prescale_i,
  output logic              tick_o
);

  logic [TICK_W-1:0] cnt_q;
  logic [TICK_W-1:0] cnt_d;

  // Wrapping on >= keeps the counter from running the full range when the
  // prescale register is lowered below the current count.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr_i || (cnt_q >= prescale_i)) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick_o = (cnt_q == prescale_i);

endmodule

// File: rtl/pwm_duty_sequencer.sv
// PWM configuration register bank with an autonomous duty-cycle ramp engine
// (one-shot or triangle), arbitrated against host writes.
module pwm_duty_sequencer
  import pwm_regs_pkg::*;
#(
  parameter int TICK_W = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       wr_valid,
  input  logic [6:0] wr_addr,
  input  logic [7:0] wr_data,
  output logic [7:0] en_reg_out_7_0,
  output logic [7:0] en_reg_out_15_8,
  output logic [7:0] en_reg_pwm_7_0,
  output logic [7:0] en_reg_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       busy,
  output logic       ramp_done
);

  seq_state_t        state_q, state_d;
  logic [7:0]        en_out_lo_q, en_out_lo_d;
  logic [7:0]        en_out_hi_q, en_out_hi_d;
  logic [7:0]        en_pwm_lo_q, en_pwm_lo_d;
  logic [7:0]        en_pwm_hi_q, en_pwm_hi_d;
  logic [7:0]        duty_q, duty_d;
  logic [7:0]        target_q, target_d;
  logic [7:0]        step_q, step_d;
  logic [TICK_W-1:0] prescale_q, prescale_d;
  logic [7:0]        origin_q, origin_d;
  logic              loop_q, loop_d;
  logic              done_q, done_d;
  logic              tick_clr;
  logic              tick;
  logic              wr_hit;

  // Saturating move of cur toward tgt by stp (0 treated as 1); the extra
  // headroom bits keep the intermediate from wrapping past 0 or 255.
  function automatic logic [7:0] step_toward(input logic [7:0] cur,
                                             input logic [7:0] tgt,
                                             input logic [7:0] stp);
    logic signed [9:0] c;
    logic signed [9:0] t;
    logic signed [9:0] s;
    logic signed [9:0] n;
    c = signed'({2'b00, cur});
    t = signed'({2'b00, tgt});
    s = (stp == '0) ? 10'sd1 : signed'({2'b00, stp});
    n = c;
    if (c < t) begin
      n = c + s;
      if (n > t) n = t;
    end else if (c > t) begin
      n = c - s;
      if (n < t) n = t;
    end
    return n[7:0];
  endfunction

  ramp_tick_gen #(
    .TICK_W (TICK_W)
  ) u_tick (
    .clk        (clk),
    .rst        (rst),
    .clr_i      (tick_clr),
    .prescale_i (prescale_q),
    .tick_o     (tick)
  );

  assign wr_hit = wr_valid && (wr_addr <= ADDR_RAMP_CTRL);

  always_comb begin
    state_d     = state_q;
    en_out_lo_d = en_out_lo_q;
    en_out_hi_d = en_out_hi_q;
    en_pwm_lo_d = en_pwm_lo_q;
    en_pwm_hi_d = en_pwm_hi_q;
    duty_d      = duty_q;
    target_d    = target_q;
    step_d      = step_q;
    prescale_d  = prescale_q;
    origin_d    = origin_q;
    loop_d      = loop_q;
    done_d      = 1'b0;
    tick_clr    = 1'b0;

    // A mapped host write always takes the cycle; a coincident tick is dropped.
    if (wr_hit) begin
      case (wr_addr)
        ADDR_EN_OUT_LO:     en_out_lo_d = wr_data;
        ADDR_EN_OUT_HI:     en_out_hi_d = wr_data;
        ADDR_EN_PWM_LO:     en_pwm_lo_d = wr_data;
        ADDR_EN_PWM_HI:     en_pwm_hi_d = wr_data;
        ADDR_DUTY: begin
          duty_d  = wr_data;
          state_d = SEQ_IDLE;
        end
        ADDR_RAMP_TARGET:   target_d   = wr_data;
        ADDR_RAMP_STEP:     step_d     = wr_data;
        ADDR_RAMP_PRESCALE: prescale_d = TICK_W'(wr_data);
        ADDR_RAMP_CTRL: begin
          if (wr_data[CTRL_STOP_BIT]) begin
            state_d = SEQ_IDLE;
          end else if (wr_data[CTRL_START_BIT]) begin
            state_d  = SEQ_RAMP;
            origin_d = duty_q;
            loop_d   = wr_data[CTRL_LOOP_BIT];
            tick_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end else if ((state_q == SEQ_RAMP) && tick) begin
      if (duty_q != target_q) begin
        duty_d = step_toward(duty_q, target_q, step_q);
      end else if (loop_q) begin
        target_d = origin_q;
        origin_d = target_q;
      end else begin
        state_d = SEQ_IDLE;
        done_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= SEQ_IDLE;
      en_out_lo_q <= '0;
      en_out_hi_q <= '0;
      en_pwm_lo_q <= '0;
      en_pwm_hi_q <= '0;
      duty_q      <= '0;
      target_q    <= '0;
      step_q      <= '0;
      prescale_q  <= '0;
      origin_q    <= '0;
      loop_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      en_out_lo_q <= en_out_lo_d;
      en_out_hi_q <= en_out_hi_d;
      en_pwm_lo_q <= en_pwm_lo_d;
      en_pwm_hi_q <= en_pwm_hi_d;
      duty_q      <= duty_d;
      target_q    <= target_d;
      step_q      <= step_d;
      prescale_q  <= prescale_d;
      origin_q    <= origin_d;
      loop_q      <= loop_d;
      done_q      <= done_d;
    end
  end

  assign en_reg_out_7_0  = en_out_lo_q;
  assign en_reg_out_15_8 = en_out_hi_q;
  assign en_reg_pwm_7_0  = en_pwm_lo_q;
  assign en_reg_pwm_15_8 = en_pwm_hi_q;
  assign pwm_duty_cycle  = duty_q;
  assign busy            = (state_q == SEQ_RAMP);
  assign ramp_done       = done_q;

endmodule
